as_pc_gen: RTL and testbench

//  Parametrised program-counter generator for the pipelined RV64I core; successor to the plain PC register.

---
 rtl/as_pc_gen_pkg.sv | 29 ++
 rtl/as_pc_gen_if.sv | 38 +++
 rtl/as_pc_redirect_latch.sv | 66 ++++++
 rtl/as_pc_gen.sv | 117 +++++++++++
 tb/tb_as_pc_gen.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/as_pc_gen_pkg.sv
// ----------------------------------------------------------------------------
// as_pc_gen_pkg
//   Shared types and constants for the IF-stage program-counter generator.
//   Contents:
//     PC_IADDR_W     default fetch-address width
//     PC_RESET_VEC   PC loaded by reset
//     PC_TRAP_VEC    PC loaded on trap or misaligned redirect
//     PC_INSTR_BYTES sequential increment
//     pc_state_t     boot / run / debug-halt state
//     is_misaligned  true when a redirect target is not word aligned
// ----------------------------------------------------------------------------
package as_pc_gen_pkg;

    localparam int              PC_IADDR_W     = 64;
    localparam logic [63:0]     PC_RESET_VEC   = 64'h0;
    localparam logic [63:0]     PC_TRAP_VEC    = 64'h100;
    localparam int              PC_INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_HALT
    } pc_state_t;

    function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
        return addr_lsbs != 2'b00;
    endfunction

endpackage

// File: rtl/as_pc_gen_if.sv
// ----------------------------------------------------------------------------
// as_pc_gen_if
//   Fetch-side bundle between the PC generator and its environment.
//   Signals:
//     fetch_ready_i  instruction memory accepts the address
//     fetch_valid_o  PC_o is a valid fetch request
//     PC_o           current fetch PC
//     PCplus_o       PC_o + instruction size
//     br_taken_i     EX-stage redirect request (1-cycle pulse)
//     br_target_i    redirect target
//     trap_i         exception / ecall (1-cycle pulse)
//   Modports:
//     master  PC generator side
//     slave   fetch unit / EX stage side
// ----------------------------------------------------------------------------
interface as_pc_gen_if
    import as_pc_gen_pkg::*;
#(
    parameter int IADDR_W = PC_IADDR_W
);
    logic               fetch_ready_i;
    logic               fetch_valid_o;
    logic [IADDR_W-1:0] PC_o;
    logic [IADDR_W-1:0] PCplus_o;
    logic               br_taken_i;
    logic [IADDR_W-1:0] br_target_i;
    logic               trap_i;

    modport master (
        input  fetch_ready_i, br_taken_i, br_target_i, trap_i,
        output fetch_valid_o, PC_o, PCplus_o
    );

    modport slave (
        output fetch_ready_i, br_taken_i, br_target_i, trap_i,
        input  fetch_valid_o, PC_o, PCplus_o
    );
endinterface

// File: rtl/as_pc_redirect_latch.sv
// ----------------------------------------------------------------------------
// as_pc_redirect_latch
//   Holds one redirect that arrived while fetch could not advance.
//   A newer redirect replaces the held one, except that a held trap is never
//   replaced by a plain branch.
//   Ports:
//     clk_i, rst_i        clock, synchronous active-high reset
//     i_load              redirect arrived and PC cannot advance this cycle
//     i_clear             PC advances this cycle (pending consumed/superseded)
//     i_is_trap           the arriving redirect is a trap
//     i_addr              the arriving redirect target
//     o_pend_valid        a redirect is held
//     o_pend_addr         held target
//     o_pend_valid_nxt    value o_pend_valid takes at the next edge
// ----------------------------------------------------------------------------
module as_pc_redirect_latch
    import as_pc_gen_pkg::*;
#(
    parameter int IADDR_W = PC_IADDR_W
)(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               i_load,
    input  logic               i_clear,
    input  logic               i_is_trap,
    input  logic [IADDR_W-1:0] i_addr,
    output logic               o_pend_valid,
    output logic [IADDR_W-1:0] o_pend_addr,
    output logic               o_pend_valid_nxt
);
    logic               r_pend_valid;
    logic               r_pend_is_trap;
    logic [IADDR_W-1:0] r_pend_addr;
    logic               w_take;

    assign w_take = i_load && !(r_pend_valid && r_pend_is_trap && !i_is_trap);

    // NOTE: every always_comb output gets a value on every path (here the
    // first assignment acts as the default), otherwise a latch is inferred.
    always_comb begin
        o_pend_valid_nxt = r_pend_valid;
        if (i_clear)
            o_pend_valid_nxt = 1'b0;
        else if (i_load)
            o_pend_valid_nxt = 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pend_valid   <= 1'b0;
            r_pend_is_trap <= 1'b0;
            r_pend_addr    <= '0;
        end else begin
            r_pend_valid <= o_pend_valid_nxt;
            if (w_take) begin
                r_pend_addr    <= i_addr;
                r_pend_is_trap <= i_is_trap;
            end
        end
    end

    assign o_pend_valid = r_pend_valid;
    assign o_pend_addr  = r_pend_addr;
endmodule

// File: rtl/as_pc_gen.sv
// ----------------------------------------------------------------------------
// as_pc_gen
//   IF-stage program-counter generator. Advances the fetch PC when the stage
//   can proceed, applies branch/trap redirects (holding them across stalls),
//   and supports debug halt/resume.
//   Ports:
//     clk_i, rst_i        clock, synchronous active-high reset
//     stall_n_i           0 = pipeline stall, hold PC
//     halt_i, resume_i    debug halt / resume requests
//     fetch_if            fetch bundle (ready/valid, PC, PC+4, redirect inputs)
//     halted_o            core is in debug halt
//     misalign_o          1-cycle pulse: branch target had bits[1:0] != 0
// ----------------------------------------------------------------------------
module as_pc_gen
    import as_pc_gen_pkg::*;
#(
    parameter int                 IADDR_W     = PC_IADDR_W,
    parameter logic [IADDR_W-1:0] RESET_VEC   = IADDR_W'(PC_RESET_VEC),
    parameter logic [IADDR_W-1:0] TRAP_VEC    = IADDR_W'(PC_TRAP_VEC),
    parameter int                 INSTR_BYTES = PC_INSTR_BYTES
)(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_n_i,
    input  logic        halt_i,
    input  logic        resume_i,
    as_pc_gen_if.master fetch_if,
    output logic        halted_o,
    output logic        misalign_o
);
    pc_state_t          r_state;
    pc_state_t          w_state_nxt;
    logic [IADDR_W-1:0] r_pc;
    logic [IADDR_W-1:0] w_pc_nxt;
    logic [IADDR_W-1:0] w_pc_plus;
    logic               r_fetch_valid;
    logic               r_halted;
    logic               r_misalign;

    logic               w_adv;
    logic               w_redir;
    logic               w_br_misaligned;
    logic [IADDR_W-1:0] w_target;
    logic               w_pend_valid;
    logic               w_pend_valid_nxt;
    logic [IADDR_W-1:0] w_pend_addr;

    assign w_adv   = (r_state == S_RUN) && stall_n_i && fetch_if.fetch_ready_i;
    assign w_redir = fetch_if.trap_i || fetch_if.br_taken_i;

    // A trap in the same cycle masks the branch, so only a lone branch can
    // raise the misalignment pulse.
    assign w_br_misaligned = fetch_if.br_taken_i && !fetch_if.trap_i &&
                             is_misaligned(fetch_if.br_target_i[1:0]);
    assign w_target  = (fetch_if.trap_i || w_br_misaligned) ? TRAP_VEC
                                                            : fetch_if.br_target_i;
    assign w_pc_plus = r_pc + IADDR_W'(INSTR_BYTES);

    as_pc_redirect_latch #(
        .IADDR_W (IADDR_W)
    ) u_redirect_latch (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .i_load           (w_redir && !w_adv),
        .i_clear          (w_adv),
        .i_is_trap        (fetch_if.trap_i),
        .i_addr           (w_target),
        .o_pend_valid     (w_pend_valid),
        .o_pend_addr      (w_pend_addr),
        .o_pend_valid_nxt (w_pend_valid_nxt)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_BOOT:  w_state_nxt = S_RUN;
            S_RUN:   if (halt_i) w_state_nxt = S_HALT;
            S_HALT:  if (resume_i && !halt_i) w_state_nxt = S_RUN;
            default: w_state_nxt = S_BOOT;
        endcase
    end

    always_comb begin
        if (w_redir && w_adv)
            w_pc_nxt = w_target;
        else if (w_pend_valid && w_adv)
            w_pc_nxt = w_pend_addr;
        else if (w_adv)
            w_pc_nxt = w_pc_plus;
        else
            w_pc_nxt = r_pc;
    end

    // Status outputs are registered from next-state values so they change on
    // the same edge as the state and pending flag they describe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= S_BOOT;
            r_pc          <= RESET_VEC;
            r_fetch_valid <= 1'b0;
            r_halted      <= 1'b0;
            r_misalign    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_fetch_valid <= (w_state_nxt == S_RUN) && !w_pend_valid_nxt;
            r_halted      <= (w_state_nxt == S_HALT);
            r_misalign    <= w_br_misaligned;
        end
    end

    assign fetch_if.PC_o          = r_pc;
    assign fetch_if.PCplus_o      = w_pc_plus;
    assign fetch_if.fetch_valid_o = r_fetch_valid;
    assign halted_o               = r_halted;
    assign misalign_o             = r_misalign;
endmodule

// File: tb/tb_as_pc_gen.sv
// ----------------------------------------------------------------------------
// tb_as_pc_gen
//   Directed bench for as_pc_gen. A behavioural model tracks the expected PC,
//   mode and queued redirect; a compare process checks every output on each
//   falling edge, and literal checks after key steps pin the model.
// ----------------------------------------------------------------------------
module tb_as_pc_gen;
    localparam logic [63:0] TRAPV = 64'h100;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic stall_n_i = 1'b1;
    logic halt_i = 1'b0;
    logic resume_i = 1'b0;
    logic halted_o;
    logic misalign_o;

    as_pc_gen_if fif ();

    as_pc_gen dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .stall_n_i  (stall_n_i),
        .halt_i     (halt_i),
        .resume_i   (resume_i),
        .fetch_if   (fif),
        .halted_o   (halted_o),
        .misalign_o (misalign_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [63:0] addr;
        bit          trap;
    } pend_t;

    pend_t       pend_q[$];
    int          m_mode;      // 0 boot, 1 running, 2 debug-halted
    logic [63:0] m_pc;
    bit          m_mis;

    task automatic model_step();
        bit          adv;
        bit          mis;
        logic [63:0] tgt;
        pend_t       p;
        if (rst_i) begin
            m_pc = 64'h0; m_mode = 0; m_mis = 0; pend_q.delete();
            return;
        end
        adv = (m_mode == 1) && stall_n_i && fif.fetch_ready_i;
        mis = fif.br_taken_i && !fif.trap_i && (fif.br_target_i % 4 != 0);
        tgt = (fif.trap_i || mis) ? TRAPV : fif.br_target_i;
        m_mis = mis;
        if (fif.trap_i || fif.br_taken_i) begin
            if (adv) begin
                m_pc = tgt;
                pend_q.delete();
            end else if (!(pend_q.size() > 0 && pend_q[0].trap && !fif.trap_i)) begin
                p.addr = tgt;
                p.trap = fif.trap_i;
                pend_q.delete();
                pend_q.push_back(p);
            end
        end else if (adv && pend_q.size() > 0) begin
            m_pc = pend_q[0].addr;
            pend_q.delete();
        end else if (adv) begin
            m_pc = m_pc + 64'd4;
        end
        if (m_mode == 0)
            m_mode = 1;
        else if (m_mode == 1 && halt_i)
            m_mode = 2;
        else if (m_mode == 2 && resume_i && !halt_i)
            m_mode = 1;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("pc",          fif.PC_o, m_pc);
            check("pcplus",      fif.PCplus_o, m_pc + 64'd4);
            check("fetch_valid", 64'(fif.fetch_valid_o), 64'((m_mode == 1) && (pend_q.size() == 0)));
            check("halted",      64'(halted_o), 64'(m_mode == 2));
            check("misalign",    64'(misalign_o), 64'(m_mis));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic br(input logic [63:0] tgt);
        fif.br_taken_i  = 1'b1;
        fif.br_target_i = tgt;
    endtask

    task automatic idle();
        fif.br_taken_i = 1'b0;
        fif.trap_i     = 1'b0;
    endtask

    initial begin
        fif.fetch_ready_i = 1'b1;
        fif.br_taken_i    = 1'b0;
        fif.br_target_i   = '0;
        fif.trap_i        = 1'b0;

        // Reset, boot, sequential fetch
        step();
        chk_en = 1'b1;
        check("rst_pc", fif.PC_o, 64'h0);
        check("rst_valid", 64'(fif.fetch_valid_o), 64'h0);
        check("rst_halted", 64'(halted_o), 64'h0);
        rst_i = 1'b0;
        step(); check("run0_pc", fif.PC_o, 64'h0); check("run0_valid", 64'(fif.fetch_valid_o), 64'h1);
        step(); check("seq_4", fif.PC_o, 64'h4);
        step(); check("seq_8", fif.PC_o, 64'h8);
        step(); check("seq_c", fif.PC_o, 64'hC);
        step(); check("seq_10", fif.PC_o, 64'h10);

        // Unstalled redirect
        br(64'h80); step(); check("br_80", fif.PC_o, 64'h80);
        idle();     step(); check("br_84", fif.PC_o, 64'h84);

        // Redirect under a 3-cycle stall
        br(64'h20); step(); check("br_20", fif.PC_o, 64'h20);
        stall_n_i = 1'b0; br(64'h200); step();
        check("stall_pc", fif.PC_o, 64'h20);
        check("stall_valid", 64'(fif.fetch_valid_o), 64'h0);
        idle(); step(); step();
        check("stall3_pc", fif.PC_o, 64'h20);
        stall_n_i = 1'b1; step();
        check("release_pc", fif.PC_o, 64'h200);
        check("release_valid", 64'(fif.fetch_valid_o), 64'h1);
        step(); check("release_next", fif.PC_o, 64'h204);

        // Trap beats branch
        br(64'h40); fif.trap_i = 1'b1; step(); check("trap_br", fif.PC_o, 64'h100);
        idle(); step(); check("trap_next", fif.PC_o, 64'h104);

        // Misaligned target
        br(64'h42); step();
        check("mis_pc", fif.PC_o, 64'h100);
        check("mis_pulse", 64'(misalign_o), 64'h1);
        idle(); step();
        check("mis_clear", 64'(misalign_o), 64'h0);
        check("mis_next", fif.PC_o, 64'h104);

        // Pending trap survives a later branch
        stall_n_i = 1'b0; fif.trap_i = 1'b1; step();
        fif.trap_i = 1'b0; br(64'h300); step();
        idle(); stall_n_i = 1'b1; step();
        check("pend_trap_kept", fif.PC_o, 64'h100);

        // Pending branch replaced by newer branch
        stall_n_i = 1'b0; br(64'h400); step();
        br(64'h500); step();
        idle(); stall_n_i = 1'b1; step();
        check("pend_br_newer", fif.PC_o, 64'h500);

        // Debug halt / resume
        br(64'h30); step(); check("halt_setup", fif.PC_o, 64'h30);
        idle(); halt_i = 1'b1; step();
        check("halt_enter", 64'(halted_o), 64'h1);
        halt_i = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("halt_hold_pc", fif.PC_o, 64'h34);
        check("halt_hold_valid", 64'(fif.fetch_valid_o), 64'h0);
        resume_i = 1'b1; step();
        check("resume_pc", fif.PC_o, 64'h34);
        check("resume_halted", 64'(halted_o), 64'h0);
        resume_i = 1'b0; step(); check("resume_next", fif.PC_o, 64'h38);

        // Halt during stall with a pending redirect
        stall_n_i = 1'b0; br(64'h600); step();
        idle(); halt_i = 1'b1; step();
        halt_i = 1'b0; stall_n_i = 1'b1; step(); step();
        check("halt_stall_pc", fif.PC_o, 64'h38);
        resume_i = 1'b1; step();
        check("resume_pend_valid", 64'(fif.fetch_valid_o), 64'h0);
        resume_i = 1'b0; step();
        check("resume_pend_pc", fif.PC_o, 64'h600);

        // Fetch not ready holds PC
        fif.fetch_ready_i = 1'b0; step(); check("notready_pc", fif.PC_o, 64'h600);
        fif.fetch_ready_i = 1'b1; step(); check("ready_pc", fif.PC_o, 64'h604);

        // Wrap-around
        br(64'hFFFF_FFFF_FFFF_FFFC); step();
        check("wrap_plus", fif.PCplus_o, 64'h0);
        idle(); step(); check("wrap_pc", fif.PC_o, 64'h0);

        // halt_i wins over resume_i, then reset mid-halt
        halt_i = 1'b1; step();
        resume_i = 1'b1; step();
        check("halt_wins", 64'(halted_o), 64'h1);
        halt_i = 1'b0; resume_i = 1'b0; rst_i = 1'b1; step();
        check("midrst_pc", fif.PC_o, 64'h0);
        check("midrst_halted", 64'(halted_o), 64'h0);
        check("midrst_valid", 64'(fif.fetch_valid_o), 64'h0);

        // Redirect arriving in boot is held until first advance
        rst_i = 1'b0; br(64'h700); step();
        check("boot_br_valid", 64'(fif.fetch_valid_o), 64'h0);
        idle(); step();
        check("boot_br_pc", fif.PC_o, 64'h700);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
